// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle between the pipeline core, the NIC and the data memory.
// "slave" is the arbiter's view; "master" is the view of the environment
// that drives the requests and returns memory read data.
interface dmem_port_arbiter_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32
);
    // Core request side
    logic                  core_req;
    logic                  core_we;
    logic [ADDR_WIDTH-1:0] core_addr;
    logic [DATA_WIDTH-1:0] core_wdata;
    logic                  core_gnt;
    logic                  core_stall;
    logic                  core_rvalid;
    logic [DATA_WIDTH-1:0] core_rdata;

    // NIC request side
    logic                  nic_req;
    logic                  nic_we;
    logic [ADDR_WIDTH-1:0] nic_addr;
    logic [DATA_WIDTH-1:0] nic_wdata;
    logic                  nic_lock;
    logic                  nic_gnt;
    logic                  nic_rvalid;
    logic [DATA_WIDTH-1:0] nic_rdata;

    // Data memory side
    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_din;
    logic [DATA_WIDTH-1:0] mem_dout;

    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        output core_gnt, core_stall, core_rvalid, core_rdata,
        input  nic_req, nic_we, nic_addr, nic_wdata, nic_lock,
        output nic_gnt, nic_rvalid, nic_rdata,
        output mem_en, mem_we, mem_addr, mem_din,
        input  mem_dout
    );

    modport master (
        output core_req, core_we, core_addr, core_wdata,
        input  core_gnt, core_stall, core_rvalid, core_rdata,
        output nic_req, nic_we, nic_addr, nic_wdata, nic_lock,
        input  nic_gnt, nic_rvalid, nic_rdata,
        input  mem_en, mem_we, mem_addr, mem_din,
        output mem_dout
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter: the core normally wins, the NIC is force-granted
// after STARVE_LIMIT waiting cycles, and the NIC may lock the port for a
// burst of at most BURST_MAX beats. Grants are combinational; read data
// returns one cycle after the grant.
module dmem_port_arbiter #(
    parameter int DATA_WIDTH   = 64,
    parameter int ADDR_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int BURST_MAX    = 8
) (
    input logic clk,
    input logic rst,
    dmem_port_arbiter_if.slave bus
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int BW = $clog2(BURST_MAX + 1);

    typedef enum logic [0:0] {ARB, NIC_BURST} state_t;

    state_t                state;
    logic [SW-1:0]         starve_cnt;
    logic [BW-1:0]         beat_cnt;
    logic                  core_gnt_c;
    logic                  nic_gnt_c;
    logic                  core_vld_p1;
    logic                  nic_vld_p1;
    logic [BW-1:0]         beat_nxt;
    logic [ADDR_WIDTH-1:0] addr_mux;
    logic [DATA_WIDTH-1:0] din_mux;

    // Starvation counter increment, holding at the limit
    function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
        return (v == SW'(STARVE_LIMIT)) ? v : v + SW'(1);
    endfunction

    assign beat_nxt = beat_cnt + BW'(1);

    // Grant selection: starvation override, then core priority, then NIC; burst state locks out the core
    always_comb begin
        core_gnt_c = 1'b0;
        nic_gnt_c  = 1'b0;
        if (rst) begin
            case (state)
                ARB: begin
                    if (starve_cnt == SW'(STARVE_LIMIT) && bus.nic_req)
                        nic_gnt_c = 1'b1;
                    else if (bus.core_req)
                        core_gnt_c = 1'b1;
                    else if (bus.nic_req)
                        nic_gnt_c = 1'b1;
                end
                NIC_BURST: nic_gnt_c = bus.nic_req;
                default: ;
            endcase
        end
    end

    // Memory port mux: address/data follow the winner, strobes only when a grant exists
    always_comb begin
        addr_mux = nic_gnt_c ? bus.nic_addr  : bus.core_addr;
        din_mux  = nic_gnt_c ? bus.nic_wdata : bus.core_wdata;
    end

    assign bus.core_gnt    = core_gnt_c;
    assign bus.nic_gnt     = nic_gnt_c;
    assign bus.core_stall  = bus.core_req & ~core_gnt_c;
    assign bus.mem_en      = core_gnt_c | nic_gnt_c;
    assign bus.mem_we      = (core_gnt_c & bus.core_we) | (nic_gnt_c & bus.nic_we);
    assign bus.mem_addr    = addr_mux;
    assign bus.mem_din     = din_mux;
    // Read-return stage: valid is suppressed while reset is asserted so in-flight data is dropped
    assign bus.core_rvalid = core_vld_p1 & rst;
    assign bus.nic_rvalid  = nic_vld_p1 & rst;
    assign bus.core_rdata  = bus.mem_dout;
    assign bus.nic_rdata   = bus.mem_dout;

    // Arbitration state, starvation/beat counters and read-valid pipe
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ARB;
            starve_cnt  <= '0;
            beat_cnt    <= '0;
            core_vld_p1 <= 1'b0;
            nic_vld_p1  <= 1'b0;
        end else begin
            core_vld_p1 <= core_gnt_c & ~bus.core_we;
            nic_vld_p1  <= nic_gnt_c & ~bus.nic_we;

            if (!bus.nic_req || nic_gnt_c)
                starve_cnt <= '0;
            else
                starve_cnt <= sat_inc(starve_cnt);

            case (state)
                ARB: begin
                    if (nic_gnt_c && bus.nic_lock) begin
                        state    <= NIC_BURST;
                        beat_cnt <= BW'(1);
                    end
                end
                NIC_BURST: begin
                    if (nic_gnt_c)
                        beat_cnt <= beat_nxt;
                    // Leave on lock release or when this beat is the last allowed one
                    if (!bus.nic_lock || (nic_gnt_c && beat_nxt == BW'(BURST_MAX))) begin
                        state      <= ARB;
                        starve_cnt <= '0;
                        beat_cnt   <= '0;
                    end
                end
                default: state <= ARB;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter (STARVE_LIMIT=4, BURST_MAX=8).
// Inputs change just after the falling edge; outputs are sampled 1 ns later.
module tb_dmem_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    dmem_port_arbiter_if #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) bus ();

    dmem_port_arbiter #(
        .DATA_WIDTH(64), .ADDR_WIDTH(32), .STARVE_LIMIT(4), .BURST_MAX(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic creq, input logic cwe, input logic nreq,
                         input logic nwe, input logic nlock);
        bus.core_req = creq;
        bus.core_we  = cwe;
        bus.nic_req  = nreq;
        bus.nic_we   = nwe;
        bus.nic_lock = nlock;
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            next_cycle();
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            #1;
        end
    endtask

    initial begin
        int nic_cnt;
        bus.core_addr  = 32'h100;
        bus.core_wdata = 64'h0;
        bus.nic_addr   = 32'h200;
        bus.nic_wdata  = 64'hC0DE;
        bus.mem_dout   = 64'h0;
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

        // Reset held three cycles with both requests up
        for (int i = 0; i < 3; i++) begin
            next_cycle(); #1;
            check("rst_core_gnt", 64'(bus.core_gnt), 64'd0);
            check("rst_nic_gnt", 64'(bus.nic_gnt), 64'd0);
            check("rst_mem_en", 64'(bus.mem_en), 64'd0);
            check("rst_mem_we", 64'(bus.mem_we), 64'd0);
            check("rst_rvalid", 64'({bus.core_rvalid, bus.nic_rvalid}), 64'd0);
        end
        next_cycle(); rst = 1'b1; #1;
        check("rel_core_gnt", 64'(bus.core_gnt), 64'd1);
        check("rel_nic_gnt", 64'(bus.nic_gnt), 64'd0);
        check("rel_mem_addr", 64'(bus.mem_addr), 64'h100);
        check("rel_stall", 64'(bus.core_stall), 64'd0);
        idle(1);
        check("rel_core_rvalid", 64'(bus.core_rvalid), 64'd1);
        idle(1);

        // Core load at 0x10, data returned next cycle
        next_cycle();
        bus.core_addr = 32'h10;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); #1;
        check("ld_gnt", 64'(bus.core_gnt), 64'd1);
        check("ld_mem_en", 64'(bus.mem_en), 64'd1);
        check("ld_mem_we", 64'(bus.mem_we), 64'd0);
        check("ld_mem_addr", 64'(bus.mem_addr), 64'h10);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.mem_dout = 64'hAB; #1;
        check("ld_rvalid", 64'(bus.core_rvalid), 64'd1);
        check("ld_rdata", bus.core_rdata, 64'hAB);
        check("ld_nic_rvalid", 64'(bus.nic_rvalid), 64'd0);
        check("ld_idle_mem_en", 64'(bus.mem_en), 64'd0);

        // Core store: write strobe and data, no read response
        next_cycle();
        bus.core_addr  = 32'h20;
        bus.core_wdata = 64'h55;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0); #1;
        check("st_mem_we", 64'(bus.mem_we), 64'd1);
        check("st_mem_din", bus.mem_din, 64'h55);
        idle(1);
        check("st_no_rvalid", 64'(bus.core_rvalid), 64'd0);
        bus.core_addr = 32'h100;

        // Contention: core four cycles, NIC on the fifth, repeating
        for (int i = 1; i <= 10; i++) begin
            next_cycle();
            drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0); #1;
            check($sformatf("starve_core_gnt%0d", i), 64'(bus.core_gnt), (i % 5 == 0) ? 64'd0 : 64'd1);
            check($sformatf("starve_nic_gnt%0d", i), 64'(bus.nic_gnt), (i % 5 == 0) ? 64'd1 : 64'd0);
            check($sformatf("starve_addr%0d", i), 64'(bus.mem_addr), (i % 5 == 0) ? 64'h200 : 64'h100);
            check($sformatf("starve_stall%0d", i), 64'(bus.core_stall), (i % 5 == 0) ? 64'd1 : 64'd0);
        end
        idle(1);

        // Locked burst capped at eight beats while the core keeps requesting
        nic_cnt = 0;
        for (int i = 1; i <= 13; i++) begin
            next_cycle();
            drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1); #1;
            if (bus.nic_gnt) nic_cnt++;
            check($sformatf("burst_core_gnt%0d", i), 64'(bus.core_gnt), (i >= 5 && i <= 12) ? 64'd0 : 64'd1);
            check($sformatf("burst_nic_gnt%0d", i), 64'(bus.nic_gnt), (i >= 5 && i <= 12) ? 64'd1 : 64'd0);
            check($sformatf("burst_stall%0d", i), 64'(bus.core_stall), (i >= 5 && i <= 12) ? 64'd1 : 64'd0);
        end
        check("burst_nic_beats", 64'(nic_cnt), 64'd8);
        idle(1);

        // Lock released on the third beat: core granted on the next cycle
        next_cycle(); drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1); #1;
        check("rel3_nic_gnt1", 64'(bus.nic_gnt), 64'd1);
        next_cycle(); drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1); #1;
        check("rel3_nic_gnt2", 64'(bus.nic_gnt), 64'd1);
        check("rel3_core_blk2", 64'(bus.core_gnt), 64'd0);
        next_cycle(); drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0); #1;
        check("rel3_nic_gnt3", 64'(bus.nic_gnt), 64'd1);
        check("rel3_core_blk3", 64'(bus.core_gnt), 64'd0);
        next_cycle(); drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0); #1;
        check("rel3_core_gnt", 64'(bus.core_gnt), 64'd1);
        idle(1);

        // Lock held without a request keeps the core out until the lock drops
        next_cycle(); drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1); #1;
        check("hold_nic_gnt", 64'(bus.nic_gnt), 64'd1);
        for (int i = 0; i < 2; i++) begin
            next_cycle(); drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1); #1;
            check("hold_no_gnt", 64'({bus.core_gnt, bus.nic_gnt}), 64'd0);
            check("hold_mem_en", 64'(bus.mem_en), 64'd0);
        end
        next_cycle(); drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0); #1;
        check("hold_drop_cycle", 64'(bus.core_gnt), 64'd0);
        next_cycle(); drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0); #1;
        check("hold_core_gnt", 64'(bus.core_gnt), 64'd1);
        idle(1);

        // Reset right after a locked NIC read grant
        next_cycle(); drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1); #1;
        check("r6_nic_gnt", 64'(bus.nic_gnt), 64'd1);
        next_cycle(); rst = 1'b0; drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0); #1;
        check("r6_nic_rvalid", 64'(bus.nic_rvalid), 64'd0);
        check("r6_gnt", 64'({bus.core_gnt, bus.nic_gnt}), 64'd0);
        next_cycle(); #1;
        check("r6_nic_rvalid2", 64'(bus.nic_rvalid), 64'd0);
        next_cycle(); rst = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            if (i > 1) next_cycle();
            drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1); #1;
            check($sformatf("r6_core_gnt%0d", i), 64'(bus.core_gnt), (i == 5) ? 64'd0 : 64'd1);
            check($sformatf("r6_nic_gnt%0d", i), 64'(bus.nic_gnt), (i == 5) ? 64'd1 : 64'd0);
            check($sformatf("r6_nic_rvalid%0d", i), 64'(bus.nic_rvalid), 64'd0);
        end
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Absolute time bound so the run always terminates
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
